// File: rtl/dca_matrix_load_row_sequencer_if.sv
// Handshake bundle between the DCA front end / LSU read path and the row sequencer.
// master is the sequencer side, slave is the front end + LSU side.
interface dca_matrix_load_row_sequencer_if #(
    parameter int BW_ADDR       = 32,
    parameter int BW_STRIDE_LS3 = 16,
    parameter int BW_ROW        = 2
);
    logic                     inst_valid;
    logic                     inst_ready;
    logic [BW_ADDR-1:0]       inst_addr;
    logic [BW_STRIDE_LS3-1:0] inst_stride_ls3;
    logic [BW_ROW-1:0]        inst_num_row_m1;

    logic                     req_valid;
    logic                     req_ready;
    logic [BW_ADDR-1:0]       req_addr;
    logic [BW_ROW-1:0]        req_row_idx;
    logic                     req_last;

    logic                     rsp_done;

    modport master (
        input  inst_valid, inst_addr, inst_stride_ls3, inst_num_row_m1,
        output inst_ready,
        output req_valid, req_addr, req_row_idx, req_last,
        input  req_ready,
        input  rsp_done
    );

    modport slave (
        output inst_valid, inst_addr, inst_stride_ls3, inst_num_row_m1,
        input  inst_ready,
        input  req_valid, req_addr, req_row_idx, req_last,
        output req_ready,
        output rsp_done
    );
endinterface

// File: rtl/dca_matrix_load_row_sequencer.sv
// Row-level sequencer for DCA matrix loads: issues one addressed read per row,
// caps unretired rows, and pulses done once every row has been retired.
//
// state | meaning
// IDLE  | waiting for a matrix load instruction
// ISSUE | issuing row requests, bounded by the outstanding cap
// DRAIN | all rows issued, waiting for the remaining retirements
// DONE  | one-cycle completion pulse
module dca_matrix_load_row_sequencer #(
    parameter int BW_ADDR         = 32,
    parameter int BW_STRIDE_LS3   = 16,
    parameter int MATRIX_SIZE     = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                           clk,
    input  logic                           rstnn,
    dca_matrix_load_row_sequencer_if.master bus,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);
    localparam int BW_ROW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
    localparam int BW_OUT = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [BW_OUT-1:0] OUT_MAX = BW_OUT'(MAX_OUTSTANDING);

    generate
        if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_bad_cfg
            $error("MAX_OUTSTANDING must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [BW_ADDR-1:0]  cur_addr;
    logic [BW_ADDR-1:0]  stride_bytes;
    logic [BW_ADDR-1:0]  stride_bytes_in;
    logic [BW_ROW-1:0]   last_row;
    logic [BW_ROW-1:0]   row_idx;
    logic [BW_OUT-1:0]   outstanding;
    logic [BW_OUT-1:0]   outstanding_nxt;

    logic                inst_ready_int;
    logic                req_valid_int;
    logic                req_last_int;
    logic                inst_hs;
    logic                req_hs;
    logic                rsp_ok;
    logic                rsp_err;

    logic [BW_STRIDE_LS3+2:0] stride_wide;

    assign stride_wide     = {bus.inst_stride_ls3, 3'b000};
    assign stride_bytes_in = BW_ADDR'(stride_wide);

    // All request-side outputs decode registers only; no input reaches them combinationally.
    assign inst_ready_int = (state == IDLE);
    assign req_valid_int  = (state == ISSUE) && (outstanding < OUT_MAX);
    assign req_last_int   = (state == ISSUE) && (row_idx == last_row);

    assign inst_hs = bus.inst_valid && inst_ready_int;
    assign req_hs  = req_valid_int && bus.req_ready;

    // A retirement with nothing outstanding is only legal if a request lands in the same cycle.
    assign rsp_ok  = bus.rsp_done && ((outstanding != '0) || req_hs);
    assign rsp_err = bus.rsp_done && (outstanding == '0) && !req_hs;

    always_comb begin
        outstanding_nxt = outstanding;
        case ({req_hs, rsp_ok})
            2'b10:   outstanding_nxt = outstanding + 1'b1;
            2'b01:   outstanding_nxt = outstanding - 1'b1;
            default: outstanding_nxt = outstanding;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (inst_hs) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (req_hs && req_last_int) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (outstanding_nxt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            cur_addr     <= '0;
            stride_bytes <= '0;
            last_row     <= '0;
            row_idx      <= '0;
        end else if (inst_hs) begin
            cur_addr     <= bus.inst_addr;
            stride_bytes <= stride_bytes_in;
            last_row     <= bus.inst_num_row_m1;
            row_idx      <= '0;
        end else if (req_hs) begin
            cur_addr     <= cur_addr + stride_bytes;
            row_idx      <= row_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstanding_nxt;
        end
    end

    // A stray retirement wins over the clear so a same-cycle error is never lost.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            err <= 1'b0;
        end else if (rsp_err) begin
            err <= 1'b1;
        end else if (inst_hs) begin
            err <= 1'b0;
        end
    end

    assign bus.inst_ready  = inst_ready_int;
    assign bus.req_valid   = req_valid_int;
    assign bus.req_addr    = cur_addr;
    assign bus.req_row_idx = row_idx;
    assign bus.req_last    = req_last_int;

    assign busy = (state != IDLE);
    assign done = (state == DONE);
endmodule
